key_debounce_multi: RTL and testbench

Parametrised multi-channel successor to the single-key debouncer. It debounces NUM_KEYS raw key/switch inputs, each with its own synchroniser, filter counter and hold timer. Per channel it emits press, release and long-press pulses plus a stable level, and a priority-encoded press-event summary for the front-panel controller (DDS mode/frequency keys).

---
 rtl/key_debounce_multi.sv | 149 ++++++++++++++
 tb/tb_key_debounce_multi.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer: per-channel sync, glitch filter, hold timer, edge/long pulses, press-event encoder.
// Optional auto-repeat enabled by defining KEY_REPEAT_EN.
module key_debounce_multi #(
   parameter int NUM_KEYS          = 4,
   parameter int DEBOUNCE_CYCLES   = 20000,
   parameter int LONG_PRESS_CYCLES = 1000000,
   parameter int REPEAT_CYCLES     = 200000,
   parameter int IDX_W             = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic [NUM_KEYS-1:0] key_released,
   output logic [NUM_KEYS-1:0] key_long,
   output logic [NUM_KEYS-1:0] key_repeat,
   output logic                event_valid,
   output logic [IDX_W-1:0]    event_index
);

   localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

   if (NUM_KEYS < 1 || NUM_KEYS > 16 || DEBOUNCE_CYCLES < 2 ||
       LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
      $error("key_debounce_multi: illegal parameter set");
   end

   logic [NUM_KEYS-1:0] sync_p0, sync_p1;
   logic [NUM_KEYS-1:0] stable_p2, stable_p3;
   logic [DB_W-1:0]     db_cnt   [NUM_KEYS];
   logic [HOLD_W-1:0]   hold_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] ev_vec;
   logic [IDX_W-1:0]    ev_idx;

   // stage p0/p1: two-flop synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= key_in;
         sync_p1 <= sync_p0;
      end
   end

   // stage p2: any agreeing sample restarts the run
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_p2 <= '0;
         for (int i = 0; i < NUM_KEYS; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync_p1[i] == stable_p2[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable_p2[i] <= sync_p1[i];
               db_cnt[i]    <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign key_level = stable_p2;

   // stage p3: edge pulses and hold timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable_p3    <= '0;
         key_pressed  <= '0;
         key_released <= '0;
         key_long     <= '0;
         for (int i = 0; i < NUM_KEYS; i++) hold_cnt[i] <= '0;
      end else begin
         stable_p3    <= stable_p2;
         key_pressed  <= stable_p2 & ~stable_p3;
         key_released <= ~stable_p2 & stable_p3;
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (!stable_p2[i])
               hold_cnt[i] <= '0;
            else if (hold_cnt[i] != HOLD_MAX)
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            // saturation at HOLD_MAX keeps this from re-firing until release
            key_long[i] <= stable_p2[i] && (hold_cnt[i] == HOLD_PRE);
         end
      end
   end

`ifdef KEY_REPEAT_EN
   localparam int REP_W = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
   localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

   logic [REP_W-1:0]    rep_cnt [NUM_KEYS];
   logic [NUM_KEYS-1:0] rep_act;

   // counter is primed with 1 on the key_long cycle so the first repeat lands REPEAT_CYCLES later
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_act    <= '0;
         key_repeat <= '0;
         for (int i = 0; i < NUM_KEYS; i++) rep_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_KEYS; i++) begin
            key_repeat[i] <= 1'b0;
            if (!stable_p2[i]) begin
               rep_act[i] <= 1'b0;
               rep_cnt[i] <= '0;
            end else if (key_long[i]) begin
               rep_act[i] <= 1'b1;
               rep_cnt[i] <= REP_ONE;
            end else if (rep_act[i]) begin
               key_repeat[i] <= (rep_cnt[i] == REP_LAST);
               rep_cnt[i]    <= (rep_cnt[i] == REP_LAST) ? '0 : rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign ev_vec = key_pressed | key_repeat;
`else
   assign key_repeat = '0;
   assign ev_vec     = key_pressed;
`endif

   always_comb begin
      ev_idx = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--)
         if (ev_vec[i]) ev_idx = IDX_W'(i);
   end

   // stage p4: registered event summary, lowest channel wins
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         event_valid <= 1'b0;
         event_index <= '0;
      end else begin
         event_valid <= |ev_vec;
         event_index <= ev_idx;
      end
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed testbench for key_debounce_multi (D=4, L=20, R=8, 4 keys).
module tb_key_debounce_multi;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] key_in;
   logic [N-1:0] key_level, key_pressed, key_released, key_long, key_repeat;
   logic         event_valid;
   logic [1:0]   event_index;

   int n_tests = 0;
   int n_fail  = 0;

   key_debounce_multi #(
      .NUM_KEYS(N), .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .REPEAT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_level(key_level), .key_pressed(key_pressed), .key_released(key_released),
      .key_long(key_long), .key_repeat(key_repeat),
      .event_valid(event_valid), .event_index(event_index)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_level"},    32'(key_level),    32'h0);
      check({tag, "_pressed"},  32'(key_pressed),  32'h0);
      check({tag, "_released"}, 32'(key_released), 32'h0);
      check({tag, "_long"},     32'(key_long),     32'h0);
      check({tag, "_repeat"},   32'(key_repeat),   32'h0);
      check({tag, "_evalid"},   32'(event_valid),  32'h0);
      check({tag, "_eindex"},   32'(event_index),  32'h0);
   endtask

   logic [N-1:0] acc_p, acc_r, acc_l;
   int n_long, long_edge, lvl_edge, n_rep, rep1, rep2, n_rel, n_prs;
   logic ev_rep;

   initial begin
      rst    = 1'b1;
      key_in = '0;
      ticks(3);
      check_all_zero("reset");

      // run with all keys held, then assert reset mid-cycle
      rst    = 1'b0;
      key_in = 4'b1111;
      ticks(10);
      check("pre_rst_level", 32'(key_level), 32'hF);
      #3 rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      ticks(2);
      rst   = 1'b0;
      acc_p = '0;
      for (int e = 1; e <= 6; e++) begin
         tick();
         acc_p |= key_pressed;
      end
      check("rel_no_early_press", 32'(acc_p), 32'h0);
      check("rel_level_e6", 32'(key_level), 32'hF);
      tick();
      check("rel_pressed_e7", 32'(key_pressed), 32'hF);
      check("rel_evalid_e7", 32'(event_valid), 32'h0);
      tick();
      check("rel_pressed_e8", 32'(key_pressed), 32'h0);
      check("rel_evalid_e8", 32'(event_valid), 32'h1);
      check("rel_eindex_e8", 32'(event_index), 32'h0);
      key_in = '0;
      ticks(12);

      // clean press on ch2
      key_in = 4'b0100;
      ticks(5);
      check("ch2_level_e5", 32'(key_level), 32'h0);
      tick();
      check("ch2_level_e6", 32'(key_level), 32'h4);
      check("ch2_pressed_e6", 32'(key_pressed), 32'h0);
      tick();
      check("ch2_pressed_e7", 32'(key_pressed), 32'h4);
      tick();
      check("ch2_pressed_e8", 32'(key_pressed), 32'h0);
      check("ch2_evalid", 32'(event_valid), 32'h1);
      check("ch2_eindex", 32'(event_index), 32'h2);
      key_in = '0;
      ticks(6);
      check("ch2_released_e6", 32'(key_released), 32'h0);
      tick();
      check("ch2_released_e7", 32'(key_released), 32'h4);
      tick();
      check("ch2_released_e8", 32'(key_released), 32'h0);
      ticks(6);

      // bouncing ch1: runs of 3 never reach acceptance
      acc_p = '0; acc_r = '0; acc_l = '0;
      for (int c = 0; c < 30; c++) begin
         key_in = ((c / 3) % 2 == 0) ? 4'b0010 : 4'b0000;
         tick();
         acc_p |= key_pressed;
         acc_r |= key_released;
         acc_l |= key_level;
      end
      check("bounce_pressed", 32'(acc_p), 32'h0);
      check("bounce_released", 32'(acc_r), 32'h0);
      check("bounce_level", 32'(acc_l), 32'h0);
      key_in = 4'b0010;
      ticks(6);
      check("bounce_hold_e6", 32'(key_pressed), 32'h0);
      tick();
      check("bounce_hold_e7", 32'(key_pressed), 32'h2);
      key_in = '0;
      ticks(14);

      // long press on ch0
      key_in = 4'b0001;
      n_long = 0; long_edge = 0; lvl_edge = 0; n_rep = 0; rep1 = 0; rep2 = 0; ev_rep = 1'b0;
      for (int e = 1; e <= 46; e++) begin
         tick();
         if (key_level[0] && lvl_edge == 0) lvl_edge = e;
         if (key_long[0]) begin n_long++; long_edge = e; end
         if (key_repeat[0]) begin
            n_rep++;
            if (rep1 == 0) rep1 = e; else if (rep2 == 0) rep2 = e;
         end
         if (e == 35) ev_rep = event_valid && (event_index == 2'd0);
      end
      check("long_level_edge", 32'(lvl_edge), 32'd6);
      check("long_count", 32'(n_long), 32'd1);
      check("long_edge", 32'(long_edge), 32'd26);
`ifdef KEY_REPEAT_EN
      check("rep_first", 32'(rep1), 32'd34);
      check("rep_second", 32'(rep2), 32'd42);
      check("rep_event", 32'(ev_rep), 32'd1);
`else
      check("rep_none", 32'(n_rep), 32'd0);
`endif
      key_in = '0;
      ticks(6);
      n_rep = 0;
      for (int e = 0; e < 20; e++) begin
         tick();
         if (key_repeat[0]) n_rep++;
      end
      check("rep_after_release", 32'(n_rep), 32'd0);

      // short 15-cycle hold on ch3
      key_in = 4'b1000;
      n_long = 0; n_rel = 0; n_prs = 0;
      for (int e = 1; e <= 40; e++) begin
         tick();
         if (e == 15) key_in = '0;
         if (key_long[3]) n_long++;
         if (key_released[3]) n_rel++;
         if (key_pressed[3]) n_prs++;
      end
      check("short_long", 32'(n_long), 32'd0);
      check("short_released", 32'(n_rel), 32'd1);
      check("short_pressed", 32'(n_prs), 32'd1);

      // simultaneous presses ch1 and ch3
      key_in = 4'b1010;
      ticks(7);
      check("simul_pressed", 32'(key_pressed), 32'hA);
      tick();
      check("simul_evalid", 32'(event_valid), 32'h1);
      check("simul_eindex", 32'(event_index), 32'h1);
      key_in = '0;
      ticks(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
